// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-port memory responder with post-reset init sweep and sticky error flag
module mem_responder #(
  parameter int                 ADDR_W     = 5,
  parameter int                 DATA_W     = 8,
  parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              err
);

  localparam int              DEPTH = 1 << ADDR_W;
  localparam logic [0:0]      INIT  = 1'b0;
  localparam logic [0:0]      IDLE  = 1'b1;
  localparam logic [ADDR_W-1:0] LAST = '1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign busy = (state == INIT);

  // Sweep owns the write port in INIT; requests only reach it in IDLE.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = data_in;
    if (rst_n) begin
      if (state == INIT) begin
        mem_we    = 1'b1;
        mem_waddr = cnt;
        mem_wdata = INIT_VALUE;
      end else if (write && !read) begin
        mem_we = 1'b1;
      end
    end
  end

  // The array is deliberately unreset; only the sweep clears it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      cnt      <= '0;
      data_out <= '0;
      err      <= 1'b0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        state <= IDLE;
      end
      if (read || write) begin
        err <= 1'b1;
      end
    end else begin
      if (read && write) begin
        err <= 1'b1;
      end else if (read) begin
        data_out <= mem[addr];
      end
    end
  end

endmodule
